// File: rtl/timer_pkg.sv
// Shared definitions for the bus-mapped down-counting timer.
package timer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;
    localparam int unsigned CTRL_IM_BIT   = 3;

    // Word offsets (Addr = byte address [3:2])
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    // Mode codes
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Codes 1x have no meaning of their own and run as one-shot.
    function automatic logic [1:0] effective_mode(input logic [1:0] mode);
        return (mode == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// 32-bit programmable down-counting timer with one-shot / auto-reload modes
// and a maskable level interrupt toward CP0.
module timer_dev
    import timer_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        Addr,
    input  logic              WE,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              IRQ
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_preset;
    logic [DATA_W-1:0] r_count;
    logic              r_irq_flag;
    state_t            r_state;

    state_t            w_state_next;
    logic              w_wr_ctrl;
    logic              w_wr_preset;
    logic              w_enable;
    logic [1:0]        w_mode;
    logic              w_load;
    logic              w_dec;
    logic              w_hw_set;
    logic              w_hw_clr_irq;
    logic              w_hw_clr_en;

    assign w_wr_ctrl   = WE && (Addr == ADDR_CTRL);
    assign w_wr_preset = WE && (Addr == ADDR_PRESET);
    assign w_enable    = r_ctrl[CTRL_EN_BIT];
    assign w_mode      = r_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB];

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state counter/flag strobes
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_hw_set     = 1'b0;
        w_hw_clr_irq = 1'b0;
        w_hw_clr_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_enable) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load       = 1'b1;
                w_state_next = ST_CNT;
            end
            ST_CNT: begin
                if (!w_enable) begin
                    w_state_next = ST_IDLE;
                end else if (r_count != '0) begin
                    w_dec = 1'b1;
                end else begin
                    w_hw_set     = 1'b1;
                    w_state_next = ST_INT;
                end
            end
            ST_INT: begin
                if (effective_mode(w_mode) == MODE_RELOAD) begin
                    w_hw_clr_irq = 1'b1;
                    w_state_next = ST_LOAD;
                end else begin
                    w_hw_clr_en  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Register file, counter and interrupt flag; software writes win over hardware
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= DataIn[CTRL_W-1:0];
            end else if (w_hw_clr_en) begin
                r_ctrl[CTRL_EN_BIT] <= 1'b0;
            end

            if (w_wr_preset) begin
                r_preset <= DataIn;
            end

            if (w_load) begin
                r_count <= r_preset;
            end else if (w_dec) begin
                r_count <= r_count - DATA_W'(1);
            end

            // A terminal-count set survives a same-edge PRESET write but not a CTRL write.
            if (w_hw_set && !w_wr_ctrl) begin
                r_irq_flag <= 1'b1;
            end else if (w_wr_ctrl || w_wr_preset || w_hw_clr_irq) begin
                r_irq_flag <= 1'b0;
            end
        end
    end

    // Zero-latency read mux; upper CTRL bits read as zero
    always_comb begin
        DataOut = '0;
        case (Addr)
            ADDR_CTRL:   DataOut = DATA_W'(r_ctrl);
            ADDR_PRESET: DataOut = r_preset;
            ADDR_COUNT:  DataOut = r_count;
            ADDR_RSVD:   DataOut = '0;
            default:     DataOut = '0;
        endcase
    end

    assign IRQ = r_irq_flag & r_ctrl[CTRL_IM_BIT];

endmodule
